// File: rtl/mulu_pkg.sv
// ---------------------------------------------------------------------------
// mulu_pkg
// Shared definitions for the digit-serial unsigned multiplier family.
//   - state_t / ST_* : FSM state encoding (IDLE, RUN, DONE)
//   - digit_count()  : number of 2-bit digits in an operand of a given width
//   - cnt_width()    : bit width of a digit counter (never less than 1)
// ---------------------------------------------------------------------------
package mulu_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Number of 2-bit digits in a WIDTH-bit operand.
    function automatic int digit_count(input int width);
        return width / 2;
    endfunction

    // Counter width able to hold 0..n-1; a single digit still needs one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : mulu_pkg

// File: rtl/mulu_x2y2.sv
// ---------------------------------------------------------------------------
// mulu_x2y2
// Combinational 2-bit x 2-bit unsigned multiplier (partial-product unit).
// Ports:
//   x [1:0] : multiplicand digit
//   y [1:0] : multiplier digit
//   p [3:0] : x * y
// ---------------------------------------------------------------------------
module mulu_x2y2 (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic [3:0] p
);

    assign p = {2'b00, x} * {2'b00, y};

endmodule : mulu_x2y2

// File: rtl/mulu_x2y2_seq.sv
// ---------------------------------------------------------------------------
// mulu_x2y2_seq
// Sequential digit-serial unsigned multiplier. Each RUN cycle one x digit and
// one y digit go through mulu_x2y2; the 4-bit partial product is shifted into
// position and added to a 2*WIDTH accumulator. Iteration: j (y digit) inner,
// i (x digit) outer. A full product takes N*N cycles, N = WIDTH/2.
//
// Parameters:
//   WIDTH : operand width (even, >= 2)
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   start : request, sampled only in IDLE or DONE
//   x, y  : operands, captured on the accepting edge
//   busy  : high while in RUN
//   rdy   : high in DONE; p holds the product
//   p     : accumulator (final product while rdy=1)
//
// Build option:
//   MULU_X2Y2_SEQ_EARLY_EXIT_EN : finish after the last row that has a
//   nonzero x digit instead of always walking all N rows. Result unchanged.
// ---------------------------------------------------------------------------
module mulu_x2y2_seq
    import mulu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 busy,
    output logic                 rdy,
    output logic [2*WIDTH-1:0]   p
);

    localparam int N  = digit_count(WIDTH);
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t               r_state;
    logic [CW-1:0]        r_i;
    logic [CW-1:0]        r_j;
    logic [WIDTH-1:0]     r_x;
    logic [WIDTH-1:0]     r_y;
    logic [2*WIDTH-1:0]   r_acc;

    logic [1:0]           w_xd;
    logic [1:0]           w_yd;
    logic [3:0]           w_pp;
    logic [CW:0]          w_dsum;
    logic [2*WIDTH-1:0]   w_term;
    logic                 w_row_last;
    logic                 w_finish;

    // Digit selection: {idx,1'b0} is 2*idx without a width-growing multiply.
    assign w_xd = r_x[{r_i, 1'b0} +: 2];
    assign w_yd = r_y[{r_j, 1'b0} +: 2];

    mulu_x2y2 u_pp (
        .x (w_xd),
        .y (w_yd),
        .p (w_pp)
    );

    // Weight of pair (i,j) is 4^(i+j): shift left by 2*(i+j) <= 2*WIDTH-4.
    assign w_dsum = {1'b0, r_i} + {1'b0, r_j};
    assign w_term = (2*WIDTH)'(w_pp) << {w_dsum, 1'b0};

    assign w_row_last = (r_j == LAST);

`ifdef MULU_X2Y2_SEQ_EARLY_EXIT_EN
    logic [CW:0]        w_inext;
    logic [WIDTH-1:0]   w_x_rest;

    // Remaining x digits above the current row; all zero means no further
    // row can contribute to the product.
    assign w_inext  = {1'b0, r_i} + (CW+1)'(1);
    assign w_x_rest = r_x >> {w_inext, 1'b0};
    assign w_finish = w_row_last && ((r_i == LAST) || (w_x_rest == '0));
`else
    assign w_finish = w_row_last && (r_i == LAST);
`endif

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_x     <= x;
                        r_y     <= y;
                        r_acc   <= '0;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_acc <= r_acc + w_term;
                    if (w_row_last) begin
                        r_j <= '0;
                        if (w_finish) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_i <= r_i + CW'(1);
                        end
                    end else begin
                        r_j <= r_j + CW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (r_state == ST_RUN);
    assign rdy  = (r_state == ST_DONE);
    assign p    = r_acc;

endmodule : mulu_x2y2_seq

// File: tb/tb_mulu_x2y2_seq.sv
// ---------------------------------------------------------------------------
// tb_mulu_x2y2_seq
// Directed self-checking bench for mulu_x2y2_seq (WIDTH=8). Inputs are driven
// and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_mulu_x2y2_seq;

    localparam int WIDTH  = 8;
    localparam int BUDGET = 64;

`ifdef MULU_X2Y2_SEQ_EARLY_EXIT_EN
    localparam int LAT_13 = 8;
    localparam int LAT_12 = 12;
`else
    localparam int LAT_13 = 16;
    localparam int LAT_12 = 16;
`endif

    logic                clk;
    logic                reset;
    logic                start;
    logic [WIDTH-1:0]    x;
    logic [WIDTH-1:0]    y;
    logic                busy;
    logic                rdy;
    logic [2*WIDTH-1:0]  p;

    int n_pass;
    int n_total;

    mulu_x2y2_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .rdy   (rdy),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for exactly one accepting edge.
    task automatic accept(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] ya);
        x     = xa;
        y     = ya;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Count edges until rdy, bounded; also count samples where busy was low
    // while still waiting.
    task automatic wait_rdy(output int edges, output int busy_gaps);
        edges     = 0;
        busy_gaps = 0;
        while (!rdy && edges < BUDGET) begin
            if (busy !== 1'b1) busy_gaps++;
            tick();
            edges++;
        end
    endtask

    task automatic check_done(input string name, input int lat, input int exp_lat,
                              input int gaps, input logic [2*WIDTH-1:0] exp_p);
        n_total++;
        if (lat !== exp_lat || rdy !== 1'b1) begin
            $display("FAIL %s_latency: got %0d edges rdy=%b, expected %0d edges rdy=1",
                     name, lat, rdy, exp_lat);
        end else n_pass++;
        n_total++;
        if (gaps !== 0) begin
            $display("FAIL %s_busy: busy low on %0d waiting cycles, expected 0", name, gaps);
        end else n_pass++;
        n_total++;
        if (p !== exp_p) begin
            $display("FAIL %s_p: got %h, expected %h", name, p, exp_p);
        end else n_pass++;
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b0;
        start = 1'b1;
        x     = 8'hFF;
        y     = 8'hFF;
        tick();
        tick();
        n_total++;
        if (p !== 16'h0000 || busy !== 1'b0 || rdy !== 1'b0) begin
            $display("FAIL reset_hold: p=%h busy=%b rdy=%b, expected 0000/0/0", p, busy, rdy);
        end else n_pass++;
        start = 1'b0;
        reset = 1'b1;
        bad   = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (busy !== 1'b0 || rdy !== 1'b0 || p !== 16'h0000) bad++;
        end
        n_total++;
        if (bad !== 0) begin
            $display("FAIL idle_no_start: %0d cycles left IDLE, expected 0", bad);
        end else n_pass++;
    endtask

    task automatic test_max();
        int lat, gaps, bad;
        accept(8'hFF, 8'hFF);
        wait_rdy(lat, gaps);
        check_done("max", lat, 16, gaps, 16'hFE01);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (rdy !== 1'b1 || busy !== 1'b0 || p !== 16'hFE01) bad++;
        end
        n_total++;
        if (bad !== 0) begin
            $display("FAIL max_hold: %0d cycles lost the result, expected 0", bad);
        end else n_pass++;
    endtask

    task automatic test_small();
        int lat, gaps;
        accept(8'd13, 8'd11);
        wait_rdy(lat, gaps);
        check_done("small", lat, LAT_13, gaps, 16'h008F);
    endtask

    task automatic test_ignore();
        int lat, gaps;
        accept(8'd200, 8'd3);
        for (int k = 0; k < 4; k++) tick();
        x     = 8'h01;
        y     = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_total++;
        if (busy !== 1'b1 || rdy !== 1'b0) begin
            $display("FAIL ignore_run: busy=%b rdy=%b after edge 5, expected 1/0", busy, rdy);
        end else n_pass++;
        wait_rdy(lat, gaps);
        check_done("ignore", lat + 5, 16, gaps, 16'd600);
    endtask

    task automatic test_reset_midrun();
        int lat, gaps;
        accept(8'hAA, 8'h55);
        for (int k = 0; k < 7; k++) tick();
        n_total++;
        if (busy !== 1'b1) begin
            $display("FAIL midrun_busy: busy=%b at edge 7, expected 1", busy);
        end else n_pass++;
        reset = 1'b0;
        #2;
        n_total++;
        if (p !== 16'h0000 || busy !== 1'b0 || rdy !== 1'b0) begin
            $display("FAIL midrun_async: p=%h busy=%b rdy=%b, expected 0000/0/0", p, busy, rdy);
        end else n_pass++;
        tick();
        reset = 1'b1;
        tick();
        n_total++;
        if (busy !== 1'b0 || rdy !== 1'b0 || p !== 16'h0000) begin
            $display("FAIL midrun_idle: p=%h busy=%b rdy=%b, expected 0000/0/0", p, busy, rdy);
        end else n_pass++;
        accept(8'h12, 8'h34);
        wait_rdy(lat, gaps);
        check_done("restart", lat, LAT_12, gaps, 16'h03A8);
    endtask

    task automatic test_back_to_back();
        int lat, gaps;
        accept(8'h80, 8'h02);
        n_total++;
        if (rdy !== 1'b0 || busy !== 1'b1 || p !== 16'h0000) begin
            $display("FAIL b2b_accept: rdy=%b busy=%b p=%h, expected 0/1/0000", rdy, busy, p);
        end else n_pass++;
        wait_rdy(lat, gaps);
        check_done("b2b", lat, 16, gaps, 16'h0100);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_max();
        test_small();
        test_ignore();
        test_reset_midrun();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_mulu_x2y2_seq
